nfet_settle_monitor: RTL and testbench

//  Clocked consumer of an nfet drain net in the discrete-logic simulation.

---
 rtl/nfet_settle_monitor_pkg.sv | 24 ++
 rtl/nfet_settle_monitor_sync_chain.sv | 30 +++
 rtl/nfet_settle_monitor.sv | 136 +++++++++++++
 tb/tb_nfet_settle_monitor.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/nfet_settle_monitor_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : q2_sim_pkg                                                       |
// | Brief   : Shared types, constants and helpers for the nfet settle monitor. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package q2_sim_pkg;

  localparam int c_cnt_w_default = 12;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } settle_state_t;

  // Saturating increment at 2**width-1; width must stay below 32.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [31:0] w_max;
    w_max = (32'd1 << width) - 32'd1;
    return (value >= w_max) ? w_max : value + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nfet_settle_monitor_sync_chain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sync_chain                                                       |
// | Brief   : Async-reset flop chain bringing the drain level into clk domain. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sync_chain #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync <= {STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/nfet_settle_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : nfet_settle_monitor                                              |
// | Brief   : Measures drain settle latency against the gate/source target.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module nfet_settle_monitor
  import q2_sim_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int CNT_W        = c_cnt_w_default,
  parameter int MAX_RISE_CYC = 40,
  parameter int MAX_FALL_CYC = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             gate,
  input  logic             source,
  input  logic             drain,
  input  logic             clr,
  output logic             drain_sync,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] last_lat,
  output logic [CNT_W-1:0] max_rise,
  output logic [CNT_W-1:0] max_fall,
  output logic             rise_viol,
  output logic             fall_viol,
  output logic [7:0]       overrun_cnt
);

  localparam logic [CNT_W-1:0] c_max_rise = CNT_W'(MAX_RISE_CYC);
  localparam logic [CNT_W-1:0] c_max_fall = CNT_W'(MAX_FALL_CYC);

  settle_state_t    r_state;
  logic             r_exp;
  logic             r_exp_prev;
  logic             r_tgt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic [CNT_W-1:0] r_last_lat;
  logic [CNT_W-1:0] r_max_rise;
  logic [CNT_W-1:0] r_max_fall;
  logic             r_rise_viol;
  logic             r_fall_viol;
  logic [7:0]       r_overrun;
  logic             w_drain_sync;
  logic             w_tchg;
  logic             w_match;

  sync_chain #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk (clk),
    .rstn(rstn),
    .d   (drain),
    .q   (w_drain_sync)
  );

  assign w_tchg  = (r_exp != r_exp_prev);
  assign w_match = (w_drain_sync == r_tgt);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_exp       <= 1'b1;
      r_exp_prev  <= 1'b1;
      r_tgt       <= 1'b1;
      r_cnt       <= '0;
      r_done      <= 1'b0;
      r_last_lat  <= '0;
      r_max_rise  <= '0;
      r_max_fall  <= '0;
      r_rise_viol <= 1'b0;
      r_fall_viol <= 1'b0;
      r_overrun   <= '0;
    end else begin
      r_exp      <= ~gate | source;
      r_exp_prev <= r_exp;
      r_done     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_tchg) begin
            r_state <= WAIT;
            r_cnt   <= CNT_W'(1);
            r_tgt   <= r_exp;
          end
        end
        WAIT: begin
          if (w_match) begin
            r_done     <= 1'b1;
            r_last_lat <= r_cnt;
            if (r_tgt) begin
              if (r_cnt > r_max_rise) r_max_rise <= r_cnt;
            end else begin
              if (r_cnt > r_max_fall) r_max_fall <= r_cnt;
            end
          end
          if (r_tgt && (r_cnt > c_max_rise)) r_rise_viol <= 1'b1;
          if (!r_tgt && (r_cnt > c_max_fall)) r_fall_viol <= 1'b1;
          // A new target always restarts the wait; only an unfinished edge counts as overrun.
          if (w_tchg) begin
            r_tgt <= r_exp;
            r_cnt <= CNT_W'(1);
            if (!w_match && (r_overrun != 8'hFF)) r_overrun <= r_overrun + 8'd1;
          end else if (w_match) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= CNT_W'(sat_inc(32'(r_cnt), CNT_W));
          end
        end
        default: r_state <= IDLE;
      endcase
      if (clr) begin
        r_max_rise  <= '0;
        r_max_fall  <= '0;
        r_rise_viol <= 1'b0;
        r_fall_viol <= 1'b0;
        r_overrun   <= '0;
      end
    end
  end

  assign drain_sync  = w_drain_sync;
  assign busy        = (r_state == WAIT);
  assign done        = r_done;
  assign last_lat    = r_last_lat;
  assign max_rise    = r_max_rise;
  assign max_fall    = r_max_fall;
  assign rise_viol   = r_rise_viol;
  assign fall_viol   = r_fall_viol;
  assign overrun_cnt = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_nfet_settle_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_nfet_settle_monitor                                           |
// | Brief   : Directed self-checking bench for nfet_settle_monitor.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_nfet_settle_monitor;

  logic        clk = 1'b0;
  logic        rstn, gate, source, drain, clr;
  logic        drain_sync, busy, done, rise_viol, fall_viol;
  logic [11:0] last_lat, max_rise, max_fall;
  logic [7:0]  overrun_cnt;
  int          ntests = 0;
  int          nfail  = 0;

  nfet_settle_monitor dut (
    .clk(clk), .rstn(rstn), .gate(gate), .source(source), .drain(drain), .clr(clr),
    .drain_sync(drain_sync), .busy(busy), .done(done), .last_lat(last_lat),
    .max_rise(max_rise), .max_fall(max_fall), .rise_viol(rise_viol),
    .fall_viol(fall_viol), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; gate = 1'b0; source = 1'b0; drain = 1'b1; clr = 1'b0;
    repeat (3) tick();
    ntests++; if ({busy, done, rise_viol, fall_viol} !== 4'b0000) begin nfail++;
      $display("FAIL reset_flags got %b expected 0000", {busy, done, rise_viol, fall_viol}); end
    ntests++; if ({last_lat, max_rise, max_fall, overrun_cnt} !== 44'd0) begin nfail++;
      $display("FAIL reset_values got %h expected 0", {last_lat, max_rise, max_fall, overrun_cnt}); end
    rstn = 1'b1;
    tick();
    ntests++; if (drain_sync !== 1'b1 || busy !== 1'b0) begin nfail++;
      $display("FAIL post_reset drain_sync=%b busy=%b expected 1/0", drain_sync, busy); end
  endtask

  task automatic test_fall();
    gate = 1'b1;
    tick(); tick();
    ntests++; if (busy !== 1'b1) begin nfail++; $display("FAIL fall_busy got %b expected 1", busy); end
    drain = 1'b0;
    tick(); tick();
    ntests++; if (done !== 1'b0) begin nfail++; $display("FAIL fall_early_done got %b expected 0", done); end
    tick();
    ntests++; if (done !== 1'b1 || busy !== 1'b0) begin nfail++;
      $display("FAIL fall_done done=%b busy=%b expected 1/0", done, busy); end
    ntests++; if (last_lat !== 12'd3 || max_fall !== 12'd3) begin nfail++;
      $display("FAIL fall_lat last_lat=%0d max_fall=%0d expected 3/3", last_lat, max_fall); end
    ntests++; if (fall_viol !== 1'b0) begin nfail++; $display("FAIL fall_viol got %b expected 0", fall_viol); end
    tick();
    ntests++; if (done !== 1'b0) begin nfail++; $display("FAIL fall_done_pulse got %b expected 0", done); end
  endtask

  task automatic test_rise();
    gate = 1'b0;
    for (int i = 1; i <= 51; i++) begin
      tick();
      if (i == 42) begin
        ntests++; if (rise_viol !== 1'b0) begin nfail++;
          $display("FAIL rise_viol_early got %b expected 0", rise_viol); end
      end
      if (i == 43) begin
        ntests++; if (rise_viol !== 1'b1 || busy !== 1'b1) begin nfail++;
          $display("FAIL rise_viol_set viol=%b busy=%b expected 1/1", rise_viol, busy); end
      end
    end
    drain = 1'b1;
    tick(); tick();
    ntests++; if (done !== 1'b0) begin nfail++; $display("FAIL rise_early_done got %b expected 0", done); end
    tick();
    ntests++; if (done !== 1'b1 || last_lat !== 12'd52) begin nfail++;
      $display("FAIL rise_done done=%b last_lat=%0d expected 1/52", done, last_lat); end
    ntests++; if (max_rise !== 12'd52 || max_fall !== 12'd3) begin nfail++;
      $display("FAIL rise_max max_rise=%0d max_fall=%0d expected 52/3", max_rise, max_fall); end
  endtask

  task automatic test_overrun();
    gate = 1'b1;
    tick(); tick(); tick();
    gate = 1'b0; drain = 1'b0;
    tick(); tick();
    ntests++; if (overrun_cnt !== 8'd1 || busy !== 1'b1) begin nfail++;
      $display("FAIL overrun overrun_cnt=%0d busy=%b expected 1/1", overrun_cnt, busy); end
    repeat (3) tick();
    ntests++; if (busy !== 1'b1 || done !== 1'b0 || last_lat !== 12'd52) begin nfail++;
      $display("FAIL overrun_hold busy=%b done=%b last_lat=%0d expected 1/0/52", busy, done, last_lat); end
  endtask

  task automatic test_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    ntests++; if ({rise_viol, fall_viol} !== 2'b00 || max_rise !== 12'd0 || max_fall !== 12'd0 || overrun_cnt !== 8'd0) begin
      nfail++; $display("FAIL clr viol=%b max_rise=%0d max_fall=%0d overrun=%0d expected all 0",
                        {rise_viol, fall_viol}, max_rise, max_fall, overrun_cnt); end
    ntests++; if (last_lat !== 12'd52 || busy !== 1'b1) begin nfail++;
      $display("FAIL clr_keep last_lat=%0d busy=%b expected 52/1", last_lat, busy); end
  endtask

  task automatic test_reset_mid_wait();
    #2 rstn = 1'b0;
    #1;
    ntests++; if (busy !== 1'b0 || done !== 1'b0 || last_lat !== 12'd0 || drain_sync !== 1'b1) begin nfail++;
      $display("FAIL async_reset busy=%b done=%b last_lat=%0d drain_sync=%b expected 0/0/0/1",
               busy, done, last_lat, drain_sync); end
    drain = 1'b1;
    tick(); tick();
    rstn = 1'b1;
    tick(); tick();
    ntests++; if (busy !== 1'b0) begin nfail++; $display("FAIL reset_release_busy got %b expected 0", busy); end
  endtask

  task automatic test_source_hold();
    source = 1'b1;
    for (int i = 0; i < 6; i++) begin
      gate = ~gate;
      tick();
      ntests++; if (busy !== 1'b0 || done !== 1'b0) begin nfail++;
        $display("FAIL source_hold step %0d busy=%b done=%b expected 0/0", i, busy, done); end
    end
  endtask

  task automatic test_immediate();
    drain = 1'b0;
    repeat (3) tick();
    gate = 1'b1; source = 1'b0;
    tick(); tick();
    ntests++; if (busy !== 1'b1) begin nfail++; $display("FAIL imm_busy got %b expected 1", busy); end
    tick();
    ntests++; if (done !== 1'b1 || last_lat !== 12'd1 || max_fall !== 12'd1 || busy !== 1'b0) begin nfail++;
      $display("FAIL imm_done done=%b last_lat=%0d max_fall=%0d busy=%b expected 1/1/1/0",
               done, last_lat, max_fall, busy); end
  endtask

  task automatic test_back_to_back();
    gate = 1'b0; drain = 1'b1;
    tick();
    gate = 1'b1;
    tick();
    ntests++; if (busy !== 1'b1) begin nfail++; $display("FAIL b2b_busy got %b expected 1", busy); end
    tick();
    ntests++; if (done !== 1'b1 || busy !== 1'b1 || last_lat !== 12'd1 || max_rise !== 12'd1 || overrun_cnt !== 8'd0) begin
      nfail++; $display("FAIL b2b_restart done=%b busy=%b last_lat=%0d max_rise=%0d overrun=%0d expected 1/1/1/1/0",
                        done, busy, last_lat, max_rise, overrun_cnt); end
    drain = 1'b0;
    tick(); tick(); tick();
    ntests++; if (done !== 1'b1 || busy !== 1'b0 || last_lat !== 12'd3 || max_fall !== 12'd3) begin nfail++;
      $display("FAIL b2b_second done=%b busy=%b last_lat=%0d max_fall=%0d expected 1/0/3/3",
               done, busy, last_lat, max_fall); end
  endtask

  initial begin
    test_reset();
    test_fall();
    test_rise();
    test_overrun();
    test_clr();
    test_reset_mid_wait();
    test_source_hold();
    test_immediate();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
`default_nettype wire
